uart_tx_scheduler: RTL and testbench

Bus master that shares the UART's 2-bit-address slave register bus between two byte-stream requesters. Each requester offers bytes over valid/ready. The block picks a winner round-robin and polls the UART status register until the TX path is not full. It then writes the byte to the UART data register. It sits between on-chip byte producers (e.g. debug console, host bridge) and the uart block, and is that block's only bus master.

---
 rtl/uart_sched_pkg.sv | 21 ++
 rtl/uart_sched_rr_arb2.sv | 29 ++
 rtl/uart_tx_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared constants and FSM state type for the UART TX scheduler.
// UART_RX_POLL_EN adds the RX read state.
package uart_sched_pkg;

  localparam logic [1:0] UART_REG_DATA   = 2'd0;
  localparam logic [1:0] UART_REG_STATUS = 2'd1;

  localparam int unsigned STATUS_FULL_BIT_DEF = 1;
  localparam int unsigned STATUS_RXV_BIT_DEF  = 0;

  typedef enum logic [2:0] {
    StIdle,
    StPoll,
    StWait,
    StWrite
`ifdef UART_RX_POLL_EN
    , StRxRead
`endif
  } sched_state_e;

endpackage

// File: rtl/uart_sched_rr_arb2.sv
// Two-way round-robin picker; the pointer moves past the committed requester.
module uart_sched_rr_arb2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic commit_i,
  input  logic commit_idx_i,
  output logic grant0_o,
  output logic grant1_o
);

  // 1 = requester 1 wins a tie
  logic ptr_q;

  always_comb begin
    grant0_o = valid0_i & (~valid1_i | ~ptr_q);
    grant1_o = valid1_i & (~valid0_i | ptr_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else if (commit_i) begin
      ptr_q <= ~commit_idx_i;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Bus master arbitrating two byte streams onto the UART register bus.
// Optional UART_RX_POLL_EN: idle status polling and RX byte readout.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int unsigned POLL_INTERVAL   = 4,
  parameter int unsigned STATUS_FULL_BIT = STATUS_FULL_BIT_DEF,
  parameter int unsigned STATUS_RXV_BIT  = STATUS_RXV_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [1:0] bus_addr,
  output logic [7:0] bus_wrdata,
  input  logic [7:0] bus_rddata,
  output logic       bus_sel,
  output logic       bus_strobe,
  output logic       bus_write,
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  localparam logic [7:0] PollLast = 8'(POLL_INTERVAL - 1);
  localparam logic [2:0] FullIdx  = 3'(STATUS_FULL_BIT);

  sched_state_e state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [7:0]   tx_byte_q, tx_byte_d;
  logic         gnt_idx_q, gnt_idx_d;
  logic         gnt0, gnt1, any_valid, full_bit;

  logic [1:0]   bus_addr_q, addr_d;
  logic [7:0]   bus_wrdata_q, wrdata_d;
  logic         bus_sel_q, sel_d, bus_write_q, write_d, busy_q;

  assign any_valid = req0_valid | req1_valid;
  assign full_bit  = bus_rddata[FullIdx];

  uart_sched_rr_arb2 u_arb (
    .clk_i       (clk),
    .rst_i       (rst),
    .valid0_i    (req0_valid),
    .valid1_i    (req1_valid),
    .commit_i    (state_q == StWrite),
    .commit_idx_i(gnt_idx_q),
    .grant0_o    (gnt0),
    .grant1_o    (gnt1)
  );

  // Handshake completes combinationally in the IDLE cycle.
  assign req0_ready = (state_q == StIdle) & ~rst & gnt0;
  assign req1_ready = (state_q == StIdle) & ~rst & gnt1;

`ifdef UART_RX_POLL_EN
  localparam logic [2:0] RxvIdx = 3'(STATUS_RXV_BIT);
  logic       tx_pend_q, tx_pend_d;
  logic       full_q, full_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rxv_bit;
  assign rxv_bit = bus_rddata[RxvIdx];
`else
  logic unused_rddata;
  assign unused_rddata = ^bus_rddata;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_byte_d = tx_byte_q;
    gnt_idx_d = gnt_idx_q;
`ifdef UART_RX_POLL_EN
    tx_pend_d  = tx_pend_q;
    full_d     = full_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          state_d   = StPoll;
          tx_byte_d = gnt1 ? req1_data : req0_data;
          gnt_idx_d = gnt1;
`ifdef UART_RX_POLL_EN
          tx_pend_d = 1'b1;
        end else if (cnt_q == PollLast) begin
          state_d   = StPoll;
          tx_pend_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      StPoll: begin
`ifdef UART_RX_POLL_EN
        full_d = full_bit;
        if (rxv_bit)         state_d = StRxRead;
        else if (!tx_pend_q) state_d = StIdle;
        else                 state_d = full_bit ? StWait : StWrite;
`else
        state_d = full_bit ? StWait : StWrite;
`endif
      end
      StWait: begin
        if (cnt_q == 8'd0) state_d = StPoll;
        else               cnt_d = cnt_q - 8'd1;
      end
      StWrite: state_d = StIdle;
`ifdef UART_RX_POLL_EN
      // The TX decision from the preceding poll resumes after the read.
      StRxRead: begin
        rx_data_d  = bus_rddata;
        rx_valid_d = 1'b1;
        if (!tx_pend_q) state_d = StIdle;
        else            state_d = full_q ? StWait : StWrite;
      end
`endif
      default: state_d = StIdle;
    endcase

    if (state_d == StWait && state_q != StWait)      cnt_d = PollLast;
    else if (state_d == StIdle && state_q != StIdle) cnt_d = 8'd0;
  end

  // Bus outputs follow the next state so they are registered, never from requester inputs.
  always_comb begin
    sel_d    = 1'b0;
    write_d  = 1'b0;
    addr_d   = UART_REG_DATA;
    wrdata_d = 8'h00;
    case (state_d)
      StPoll: begin
        sel_d  = 1'b1;
        addr_d = UART_REG_STATUS;
      end
      StWrite: begin
        sel_d    = 1'b1;
        write_d  = 1'b1;
        wrdata_d = tx_byte_d;
      end
`ifdef UART_RX_POLL_EN
      StRxRead: sel_d = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 8'd0;
      tx_byte_q    <= 8'h00;
      gnt_idx_q    <= 1'b0;
      bus_addr_q   <= 2'd0;
      bus_wrdata_q <= 8'h00;
      bus_sel_q    <= 1'b0;
      bus_write_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tx_byte_q    <= tx_byte_d;
      gnt_idx_q    <= gnt_idx_d;
      bus_addr_q   <= addr_d;
      bus_wrdata_q <= wrdata_d;
      bus_sel_q    <= sel_d;
      bus_write_q  <= write_d;
      busy_q       <= (state_d != StIdle);
    end
  end

  assign bus_addr   = bus_addr_q;
  assign bus_wrdata = bus_wrdata_q;
  assign bus_sel    = bus_sel_q;
  assign bus_strobe = bus_sel_q;
  assign bus_write  = bus_write_q;
  assign busy       = busy_q;

`ifdef UART_RX_POLL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_pend_q  <= 1'b0;
      full_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      tx_pend_q  <= tx_pend_d;
      full_q     <= full_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
`else
  assign rx_data  = 8'h00;
  assign rx_valid = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: schedule-based reference model plus
// directed scenarios with literal expectations.
module tb_uart_tx_scheduler;

  localparam int PI = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic [1:0] bus_addr;
  logic [7:0] bus_wrdata, bus_rddata, rx_data;
  logic       bus_sel, bus_strobe, bus_write, busy, rx_valid;

  logic       st_full, st_rxv;
  logic [7:0] data_reg, status_byte;

  always #5 clk = ~clk;

  always_comb begin
    status_byte    = 8'h00;
    status_byte[1] = st_full;
    status_byte[0] = st_rxv;
  end
  assign bus_rddata = (bus_addr == 2'd1) ? status_byte : data_reg;

  uart_tx_scheduler #(.POLL_INTERVAL(PI)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .bus_addr  (bus_addr),
    .bus_wrdata(bus_wrdata),
    .bus_rddata(bus_rddata),
    .bus_sel   (bus_sel),
    .bus_strobe(bus_strobe),
    .bus_write (bus_write),
    .busy      (busy),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Requester queues and observation logs
  logic [7:0] q0[$], q1[$];
  bit         acc0, acc1;
  logic [7:0] wr_q[$];
  int         wr_cyc[$], rdy_cyc[$], poll_cyc[$];

  // Reference model: a held byte, absolute cycle of next poll / write, tie pointer
  bit         mon_en = 1'b0;
  bit         m_hold = 1'b0, m_ptr = 1'b0, m_win;
  logic [7:0] m_byte;
  int         m_poll_at = -1, m_write_at = -1;

  always @(negedge clk) begin
    bit         e_r0, e_r1, e_sel, e_wr, e_busy;
    logic [1:0] e_addr;
    logic [7:0] e_wd;
    if (mon_en) begin
      e_r0 = 0; e_r1 = 0; e_sel = 0; e_wr = 0; e_addr = 2'd0; e_wd = 8'h00;
      e_busy = m_hold;
      if (!m_hold) begin
        if (!rst && (req0_valid || req1_valid)) begin
          m_win  = (req0_valid && req1_valid) ? m_ptr : req1_valid;
          e_r0   = !m_win;
          e_r1   = m_win;
          m_byte = m_win ? req1_data : req0_data;
          m_hold = 1'b1;
          m_poll_at = cyc + 1;
        end
      end else if (cyc == m_poll_at) begin
        e_sel  = 1'b1;
        e_addr = 2'd1;
        if (st_full) m_poll_at = cyc + 1 + PI;
        else         m_write_at = cyc + 1;
      end else if (cyc == m_write_at) begin
        e_sel  = 1'b1;
        e_wr   = 1'b1;
        e_wd   = m_byte;
        m_hold = 1'b0;
        m_ptr  = !m_win;
      end
      chk("ready", {req1_ready, req0_ready}, {e_r1, e_r0});
      chk("bus", {bus_sel, bus_strobe, bus_write, bus_addr, bus_wrdata},
          {e_sel, e_sel, e_wr, e_addr, e_wd});
      chk("busy", busy, e_busy);
      chk("rx_idle", {rx_valid, rx_data}, 9'h000);
      if (rst) begin
        m_hold = 1'b0;
        m_ptr  = 1'b0;
      end
    end
    if (req0_valid && req0_ready) acc0 = 1'b1;
    if (req1_valid && req1_ready) acc1 = 1'b1;
    if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) rdy_cyc.push_back(cyc);
    if (bus_strobe && bus_write) begin
      wr_q.push_back(bus_wrdata);
      wr_cyc.push_back(cyc);
    end
    if (bus_strobe && !bus_write && bus_addr == 2'd1) poll_cyc.push_back(cyc);
  end

  task automatic drive();
    req0_valid = (q0.size() > 0);
    req0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
    req1_valid = (q1.size() > 0);
    req1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (acc0) void'(q0.pop_front());
    if (acc1) void'(q1.pop_front());
    acc0 = 1'b0;
    acc1 = 1'b0;
    drive();
  endtask

  task automatic clear_logs();
    wr_q.delete(); wr_cyc.delete(); rdy_cyc.delete(); poll_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    drive();
    tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      done = (q0.size() == 0 && q1.size() == 0 && !busy);
    end
    chk({name, "_drain"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; st_full = 1'b0; st_rxv = 1'b0; data_reg = 8'h00;
    acc0 = 1'b0; acc1 = 1'b0;
    drive();
    tick();
    tick();
    @(negedge clk);
    chk("reset_outputs", {req0_ready, req1_ready, bus_addr, bus_wrdata, bus_sel, bus_strobe,
                          bus_write, busy, rx_data, rx_valid}, 32'd0);

`ifdef UART_RX_POLL_EN
    begin
      bit found = 1'b0;
      tick();
      rst = 1'b0;
      st_rxv = 1'b1;
      data_reg = 8'hA5;
      for (int i = 0; i < PI + 2 && !found; i++) begin
        tick();
        found = bus_strobe && bus_sel && !bus_write && bus_addr == 2'd0;
      end
      chk("rxread_seen", {31'd0, found}, 32'd1);
      st_rxv = 1'b0;
      tick();
      chk("rx_valid_pulse", {31'd0, rx_valid}, 32'd1);
      chk("rx_data", {24'd0, rx_data}, 32'h0000_00A5);
      tick();
      chk("rx_valid_single", {31'd0, rx_valid}, 32'd0);
    end
`else
    tick();
    rst = 1'b0;
    mon_en = 1'b1;

    // Single byte, status not full: accept, poll, write in 3 cycles
    do_reset();
    q0.push_back(8'h5A); drive();
    drain("t1");
    chk("t1_count", wr_q.size(), 32'd1);
    chk("t1_byte", {24'd0, wr_q[0]}, 32'h5A);
    chk("t1_poll_lat", poll_cyc[0] - rdy_cyc[0], 32'd1);
    chk("t1_write_lat", wr_cyc[0] - rdy_cyc[0], 32'd2);

    // Both requesters contending: strict alternation starting with req0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(8'h12);
      q1.push_back(8'h34);
    end
    drive();
    drain("t2");
    chk("t2_count", wr_q.size(), 32'd8);
    for (int i = 0; i < 8 && i < wr_q.size(); i++)
      chk("t2_order", {24'd0, wr_q[i]}, (i % 2 == 0) ? 32'h12 : 32'h34);

    // Status full for 10 cycles: polls every 1+PI cycles, one write after clearing
    do_reset();
    st_full = 1'b1;
    q0.push_back(8'h77); drive();
    for (int i = 0; i < 10; i++) tick();
    st_full = 1'b0;
    drain("t3");
    chk("t3_polls", poll_cyc.size(), 32'd3);
    chk("t3_space1", poll_cyc[1] - poll_cyc[0], 32'd5);
    chk("t3_space2", poll_cyc[2] - poll_cyc[1], 32'd5);
    chk("t3_count", wr_q.size(), 32'd1);
    chk("t3_byte", {24'd0, wr_q[0]}, 32'h77);
    chk("t3_write_lat", wr_cyc[0] - rdy_cyc[0], 32'd12);

    // Reset while waiting: held byte dropped, req0 regains tie priority
    do_reset();
    q0.push_back(8'h11); drive();
    drain("t4a");
    st_full = 1'b1;
    q1.push_back(8'h56); drive();
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    st_full = 1'b0;
    chk("t4_idle_after_rst", {busy, bus_sel, bus_strobe, bus_write, bus_addr, bus_wrdata}, 32'd0);
    q0.push_back(8'h01);
    q1.push_back(8'h02);
    drive();
    drain("t4b");
    chk("t4_count", wr_q.size(), 32'd3);
    chk("t4_w0", {24'd0, wr_q[0]}, 32'h11);
    chk("t4_w1", {24'd0, wr_q[1]}, 32'h01);
    chk("t4_w2", {24'd0, wr_q[2]}, 32'h02);

    // Streaming from req1: back-to-back at 3 cycles per byte
    do_reset();
    for (int i = 0; i < 16; i++) q1.push_back(8'(i));
    drive();
    drain("t6");
    chk("t6_count", wr_q.size(), 32'd16);
    for (int i = 0; i < 16 && i < wr_q.size(); i++) begin
      chk("t6_byte", {24'd0, wr_q[i]}, i);
      if (i > 0) chk("t6_spacing", wr_cyc[i] - wr_cyc[i-1], 32'd3);
    end
    mon_en = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
